// File: rtl/block_memory_responder.sv
// block_memory_responder: line-granular backing store answering cache fill
// and write-back requests, one at a time, after a fixed access latency.
module block_memory_responder #(
  parameter int BLOCK_SIZE = 16,
  parameter int NUM_BLOCKS = 256,
  parameter int DELAY      = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [BLOCK_SIZE*8-1:0] din,
  output logic                    is_output_valid,
  output logic [BLOCK_SIZE*8-1:0] dout,
  output logic                    mem_ready
);

  localparam int LINE_BITS   = BLOCK_SIZE * 8;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
  localparam int INDEX_BITS  = $clog2(NUM_BLOCKS);
  // A one-cycle latency still needs a one-bit counter that simply sits at 0
  localparam int COUNT_BITS  = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [COUNT_BITS-1:0] COUNT_LOAD = COUNT_BITS'(DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [COUNT_BITS-1:0]   count;
  logic [COUNT_BITS-1:0]   count_next;
  logic                    accept;
  logic                    finish;

  logic                    op_write;
  logic [INDEX_BITS-1:0]   line;
  logic [LINE_BITS-1:0]    line_data;

  logic [LINE_BITS-1:0]    storage [NUM_BLOCKS];

  // Offset bits and the bits above the line index never select anything
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:OFFSET_BITS+INDEX_BITS], addr[OFFSET_BITS-1:0]};

  // Next-state logic: accept a well-formed request in IDLE, count down the latency in WAIT
  always_comb begin
    state_next = state;
    count_next = count;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (is_input_valid && (mem_read ^ mem_write)) begin
          accept     = 1'b1;
          state_next = WAIT;
          count_next = COUNT_LOAD;
        end
      end
      WAIT: begin
        if (count == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          count_next = count - COUNT_BITS'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register plus registered outputs so nothing on the inputs reaches the outputs combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      mem_ready       <= 1'b1;
      is_output_valid <= 1'b0;
      dout            <= '0;
    end else begin
      state           <= state_next;
      count           <= count_next;
      mem_ready       <= (state_next == IDLE);
      is_output_valid <= finish && !op_write;
      dout            <= (finish && !op_write) ? storage[line] : '0;
    end
  end

  // Capture the request at acceptance so later input wiggles are ignored
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      op_write  <= mem_write;
      line      <= addr[OFFSET_BITS +: INDEX_BITS];
      line_data <= din;
    end
  end

  // Commit a write at the end of the latency; reset is not a clear for the array
  always_ff @(posedge clk) begin
    if (!reset && finish && op_write) begin
      storage[line] <= line_data;
    end
  end

endmodule

// File: tb/tb_block_memory_responder.sv
// tb_block_memory_responder: table-driven, hand-written and randomized checks
// of the block memory responder against a simple line-array reference model.
module tb_block_memory_responder;

  localparam int BS = 16;
  localparam int NB = 256;
  localparam int D  = 4;
  localparam int W  = BS * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          is_input_valid;
  logic [31:0]   addr;
  logic          mem_read;
  logic          mem_write;
  logic [W-1:0]  din;
  logic          is_output_valid;
  logic [W-1:0]  dout;
  logic          mem_ready;

  logic          is_input_valid_1;
  logic [31:0]   addr_1;
  logic          mem_read_1;
  logic          mem_write_1;
  logic [W-1:0]  din_1;
  logic          is_output_valid_1;
  logic [W-1:0]  dout_1;
  logic          mem_ready_1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model_mem [NB];

  typedef struct {
    bit           is_read;
    logic [31:0]  addr;
    logic [W-1:0] data;
    logic [W-1:0] want;
  } vec_t;

  vec_t vecs [6];

  localparam logic [W-1:0] DATA1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [W-1:0] A5S   = {16{8'hA5}};

  always #5 clk = ~clk;

  block_memory_responder #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .DELAY(D)) dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr),
    .mem_read(mem_read), .mem_write(mem_write), .din(din),
    .is_output_valid(is_output_valid), .dout(dout), .mem_ready(mem_ready)
  );

  block_memory_responder #(.BLOCK_SIZE(BS), .NUM_BLOCKS(NB), .DELAY(1)) dut_fast (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid_1), .addr(addr_1),
    .mem_read(mem_read_1), .mem_write(mem_write_1), .din(din_1),
    .is_output_valid(is_output_valid_1), .dout(dout_1), .mem_ready(mem_ready_1)
  );

  // Line number from plain address arithmetic
  function automatic int line_of(input logic [31:0] a);
    int unsigned ua;
    ua = a;
    return int'((ua / BS) % NB);
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, actual, expected);
    end
  endtask

  // One request on the DELAY=4 instance, checking every cycle until it is idle again
  task automatic applyStimulus(input bit is_read, input logic [31:0] a, input logic [W-1:0] d,
                               input logic [W-1:0] want, input bit intrude);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!mem_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!mem_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout actual=%b expected=1", mem_ready);
      return;
    end
    is_input_valid = 1'b1;
    mem_read       = is_read;
    mem_write      = !is_read;
    addr           = a;
    din            = d;
    @(posedge clk);
    if (!is_read) model_mem[line_of(a)] = d;
    #1;
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    addr           = $urandom;
    din            = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c <= D + 1; c++) begin
      @(negedge clk);
      checkBit("mem_ready", mem_ready, c == D + 1);
      checkBit("valid", is_output_valid, is_read && c == D);
      checkOutput("dout", dout, (is_read && c == D) ? want : '0);
      if (intrude && c == 1) begin
        is_input_valid = 1'b1;
        mem_write      = 1'b1;
        addr           = a ^ 32'h0000_0070;
        din            = '1;
      end
      if (intrude && c == 2) begin
        is_input_valid = 1'b0;
        mem_write      = 1'b0;
      end
    end
  endtask

  // Write one line on the DELAY=1 instance and wait until it is idle
  task automatic fastWrite(input logic [31:0] a, input logic [W-1:0] d);
    @(negedge clk);
    is_input_valid_1 = 1'b1;
    mem_write_1      = 1'b1;
    addr_1           = a;
    din_1            = d;
    @(posedge clk);
    #1;
    is_input_valid_1 = 1'b0;
    mem_write_1      = 1'b0;
    repeat (3) @(negedge clk);
    checkBit("fast_write_ready", mem_ready_1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] data;
    logic [31:0]  a;
    bit           rd;

    for (int i = 0; i < NB; i++) model_mem[i] = '0;
    reset            = 1'b1;
    is_input_valid   = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    addr             = '0;
    din              = '0;
    is_input_valid_1 = 1'b0;
    mem_read_1       = 1'b0;
    mem_write_1      = 1'b0;
    addr_1           = '0;
    din_1            = '0;

    vecs[0] = '{1'b1, 32'h0000_0040, '0,    '0};
    vecs[1] = '{1'b0, 32'h0000_0100, DATA1, '0};
    vecs[2] = '{1'b1, 32'h0000_010C, '0,    DATA1};
    vecs[3] = '{1'b0, 32'h0000_0010, A5S,   '0};
    vecs[4] = '{1'b1, 32'h0000_1010, '0,    A5S};
    vecs[5] = '{1'b1, 32'hFFFF_0107, '0,    DATA1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkBit("reset_ready", mem_ready, 1'b1);
    checkBit("reset_valid", is_output_valid, 1'b0);
    checkOutput("reset_dout", dout, '0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].is_read, vecs[i].addr, vecs[i].data, vecs[i].want, 1'b0);
    end

    // A busy-time request and a malformed idle request must both vanish
    applyStimulus(1'b0, 32'h0000_0200, DATA1 ^ A5S, '0, 1'b1);
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_read       = 1'b1;
    mem_write      = 1'b1;
    addr           = 32'h0000_0270;
    din            = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkBit("both_ready", mem_ready, 1'b1);
      checkBit("both_valid", is_output_valid, 1'b0);
    end
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    applyStimulus(1'b1, 32'h0000_0270, '0, '0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0200, '0, DATA1 ^ A5S, 1'b0);

    // Reset two cycles into a write to line 3 must drop it
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_write      = 1'b1;
    addr           = 32'h0000_0030;
    din            = '1;
    @(posedge clk);
    #1;
    is_input_valid = 1'b0;
    mem_write      = 1'b0;
    @(negedge clk);
    checkBit("pre_reset_ready", mem_ready, 1'b0);
    @(negedge clk);
    reset          = 1'b1;
    is_input_valid = 1'b1;
    mem_read       = 1'b1;
    addr           = 32'h0000_0050;
    @(negedge clk);
    reset          = 1'b0;
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    checkBit("mid_reset_ready", mem_ready, 1'b1);
    checkBit("mid_reset_valid", is_output_valid, 1'b0);
    checkOutput("mid_reset_dout", dout, '0);
    @(negedge clk);
    checkBit("reset_req_ignored", mem_ready, 1'b1);
    applyStimulus(1'b1, 32'h0000_0030, '0, model_mem[3], 1'b0);

    // Randomized traffic over a few lines with random offset and alias bits
    for (int n = 0; n < 40; n++) begin
      rd   = 1'($urandom_range(0, 1));
      a    = ($urandom & ~32'h0000_0FF0) | (32'($urandom_range(0, 7)) << 4);
      data = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rd, a, data, model_mem[line_of(a)], 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // DELAY=1: back-to-back reads of lines 1 and 2 spaced three cycles apart
    fastWrite(32'h0000_0010, DATA1);
    fastWrite(32'h0000_0020, A5S);
    is_input_valid_1 = 1'b1;
    mem_read_1       = 1'b1;
    addr_1           = 32'h0000_0010;
    @(posedge clk);
    #1;
    addr_1 = 32'h0000_0020;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checkBit("fast_ready", mem_ready_1, c == 2 || c == 5);
      checkBit("fast_valid", is_output_valid_1, c == 1 || c == 4);
      checkOutput("fast_dout", dout_1, (c == 1) ? DATA1 : (c == 4) ? A5S : '0);
      if (c == 3) begin
        is_input_valid_1 = 1'b0;
        mem_read_1       = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
